// File: rtl/lcd_bus_arbiter_pkg.sv
// Shared LCD definitions: transfer sequencer states, HD44780 command
// constants and the long-execution command classifier.
package lcd_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP_H = 3'd1,
        ST_PULSE_H = 3'd2,
        ST_SETUP_L = 3'd3,
        ST_PULSE_L = 3'd4,
        ST_WAIT    = 3'd5
    } lcd_state_e;

    localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME  = 8'h02;
    localparam logic [7:0] LCD_CMD_FUNC4 = 8'h28;
    localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_bus_arbiter_if.sv
// Requester handshake and LCD pin bundle for lcd_bus_arbiter.
// Lock inputs exist only when ARB_LOCK_EN is defined.
interface lcd_bus_arbiter_if;
    logic       req0_valid;
    logic [8:0] req0_data;
    logic       req0_nib;
    logic       req0_ready;
    logic       req1_valid;
    logic [8:0] req1_data;
    logic       req1_nib;
    logic       req1_ready;
`ifdef ARB_LOCK_EN
    logic       req0_lock;
    logic       req1_lock;
`endif
    logic       rs;
    logic       e;
    logic       d4;
    logic       d5;
    logic       d6;
    logic       d7;
    logic       busy;
    logic       grant;

    modport master (
`ifdef ARB_LOCK_EN
        output req0_lock, req1_lock,
`endif
        output req0_valid, req0_data, req0_nib,
        output req1_valid, req1_data, req1_nib,
        input  req0_ready, req1_ready,
        input  rs, e, d4, d5, d6, d7, busy, grant
    );

    modport slave (
`ifdef ARB_LOCK_EN
        input  req0_lock, req1_lock,
`endif
        input  req0_valid, req0_data, req0_nib,
        input  req1_valid, req1_data, req1_nib,
        output req0_ready, req1_ready,
        output rs, e, d4, d5, d6, d7, busy, grant
    );
endinterface

// File: rtl/lcd_bus_arbiter_rr.sv
// Two-way round-robin arbiter. Grant is combinational from the valids;
// the last-served pointer only moves when the top accepts a transfer.
// With ARB_LOCK_EN the last-served port keeps winning while it holds lock.
module lcd_bus_arbiter_rr (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] valid_i,
`ifdef ARB_LOCK_EN
    input  logic [1:0] lock_i,
`endif
    input  logic       accept_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    logic last_q;
    logic last_d;
    logic keep_last;

`ifdef ARB_LOCK_EN
    assign keep_last = lock_i[last_q];
`else
    assign keep_last = 1'b0;
`endif

    // Pick the winner: a lone requester always wins, contention goes to the other port.
    always_comb begin
        gnt_idx_o = 1'b0;
        if (valid_i == 2'b11) begin
            gnt_idx_o = keep_last ? last_q : ~last_q;
        end else begin
            gnt_idx_o = valid_i[1];
        end
        gnt_o = 2'b00;
        if (valid_i != 2'b00) begin
            gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
        end
    end

    assign last_d = accept_i ? gnt_idx_o : last_q;

    // Last-served pointer; reset value makes port 0 win the first contention.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Shares one HD44780 4-bit bus between two requesters. Each accepted
// {RS, byte} goes out as high then low nibble (or high only for NIB writes),
// followed by the command execution wait. Optional macro: ARB_LOCK_EN.
//
// state    | meaning
// IDLE     | bus free, READY may assert
// SETUP_H  | E low, high nibble on D
// PULSE_H  | E high, high nibble latched by the LCD
// SETUP_L  | E low, low nibble on D (also E-low time after first pulse)
// PULSE_L  | E high, low nibble latched
// WAIT     | E low, bus held for the command execution delay
module lcd_bus_arbiter
    import lcd_bus_arbiter_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int DLY_SHORT = 4,
    parameter int DLY_LONG  = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    lcd_bus_arbiter_if.slave  bus
);

    localparam int CNT_MAX = (CLK_DIV > DLY_LONG) ? CLK_DIV : DLY_LONG;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LD_PHASE = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(DLY_SHORT - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(DLY_LONG - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    lcd_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       lo_q;
    logic             nib_q;
    logic             long_q;
    logic             rs_q;
    logic             e_q;
    logic [3:0]       d_q;
    logic             busy_q;
    logic             grant_q;

    logic [1:0] valid;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       idle;
    logic       accept;
    logic [8:0] sel_data;
    logic       sel_nib;

    assign valid  = {bus.req1_valid, bus.req0_valid};
    assign idle   = (state_q == ST_IDLE);
    assign accept = idle && (valid != 2'b00) && rst_n_i;

    lcd_bus_arbiter_rr u_rr (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .valid_i   (valid),
`ifdef ARB_LOCK_EN
        .lock_i    ({bus.req1_lock, bus.req0_lock}),
`endif
        .accept_i  (accept),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign sel_data = gnt_idx ? bus.req1_data : bus.req0_data;
    assign sel_nib  = gnt_idx ? bus.req1_nib  : bus.req0_nib;

    // READY is the only combinational output; gated by reset so it stays low there.
    assign bus.req0_ready = idle && gnt[0] && rst_n_i;
    assign bus.req1_ready = idle && gnt[1] && rst_n_i;

    // Transfer sequencer with registered bus outputs; counter reloads on every state entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            lo_q    <= 4'h0;
            nib_q   <= 1'b0;
            long_q  <= 1'b0;
            rs_q    <= 1'b0;
            e_q     <= 1'b0;
            d_q     <= 4'h0;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
        end else if (state_q == ST_IDLE) begin
            if (accept) begin
                state_q <= ST_SETUP_H;
                cnt_q   <= LD_PHASE;
                lo_q    <= sel_data[3:0];
                nib_q   <= sel_nib;
                long_q  <= !sel_nib && is_long_cmd(sel_data[8], sel_data[7:0]);
                rs_q    <= sel_data[8];
                e_q     <= 1'b0;
                d_q     <= sel_data[7:4];
                busy_q  <= 1'b1;
                grant_q <= gnt_idx;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
        end else begin
            case (state_q)
                ST_SETUP_H: begin
                    state_q <= ST_PULSE_H;
                    cnt_q   <= LD_PHASE;
                    e_q     <= 1'b1;
                end
                ST_PULSE_H: begin
                    e_q <= 1'b0;
                    if (nib_q) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= LD_SHORT;
                    end else begin
                        state_q <= ST_SETUP_L;
                        cnt_q   <= LD_PHASE;
                        d_q     <= lo_q;
                    end
                end
                ST_SETUP_L: begin
                    state_q <= ST_PULSE_L;
                    cnt_q   <= LD_PHASE;
                    e_q     <= 1'b1;
                end
                ST_PULSE_L: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= long_q ? LD_LONG : LD_SHORT;
                    e_q     <= 1'b0;
                end
                ST_WAIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    e_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rs    = rs_q;
    assign bus.e     = e_q;
    assign bus.d4    = d_q[0];
    assign bus.d5    = d_q[1];
    assign bus.d6    = d_q[2];
    assign bus.d7    = d_q[3];
    assign bus.busy  = busy_q;
    assign bus.grant = grant_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Bench for lcd_bus_arbiter: directed scenarios then random traffic, every
// cycle compared against a timeline model (offset from the accept cycle).
module tb_lcd_bus_arbiter;
    import lcd_bus_arbiter_pkg::*;

    localparam int CD = 2;
    localparam int DS = 4;
    localparam int DL = 16;

    logic clk;
    logic rst_n;
    lcd_bus_arbiter_if bus ();

    lcd_bus_arbiter #(.CLK_DIV(CD), .DLY_SHORT(DS), .DLY_LONG(DL)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_r1  = 0;

    logic [1:0] pv;
    logic [8:0] pd [2];
    logic [1:0] pn;
    logic       rel_pend = 1'b0;
`ifdef ARB_LOCK_EN
    logic [1:0] plock;
    logic       rand_lock = 1'b0;
`endif

    int         acc_t;
    int         idle_at;
    logic [8:0] m_dat;
    logic       m_nib;
    logic       m_have;
    logic       m_last;
    logic       m_gnt;

    logic [3:0] dnib;
    assign dnib = {bus.d7, bus.d6, bus.d5, bus.d4};

    assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req0_valid && !bus.req0_ready) |=> (bus.req0_valid && $stable(bus.req0_data)))
        else $error("port0 dropped request before ready");
    assert property (@(posedge clk) disable iff (!rst_n)
        (bus.req1_valid && !bus.req1_ready) |=> (bus.req1_valid && $stable(bus.req1_data)))
        else $error("port1 dropped request before ready");

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive();
        bus.req0_valid = pv[0];
        bus.req0_data  = pd[0];
        bus.req0_nib   = pn[0];
        bus.req1_valid = pv[1];
        bus.req1_data  = pd[1];
        bus.req1_nib   = pn[1];
`ifdef ARB_LOCK_EN
        bus.req0_lock  = plock[0];
        bus.req1_lock  = plock[1];
`endif
    endtask

    task automatic q(input int p, input logic [8:0] dat, input logic nib);
        pv[p] = 1'b1;
        pd[p] = dat;
        pn[p] = nib;
    endtask

    task automatic new_req(input int p);
        logic [8:0] d;
        case ($urandom_range(5))
            0:       d = {1'b0, LCD_CMD_CLEAR};
            1:       d = {1'b0, LCD_CMD_HOME | 8'($urandom_range(1))};
            2:       d = {1'b0, LCD_CMD_FUNC4};
            3:       d = {1'b0, LCD_CMD_DDRAM | 8'($urandom_range(127))};
            4:       d = {1'b1, 8'($urandom_range(255))};
            default: d = 9'($urandom_range(511));
        endcase
        q(p, d, ($urandom_range(4) == 0));
`ifdef ARB_LOCK_EN
        if (rand_lock) plock[p] = 1'($urandom_range(1));
`endif
    endtask

    task automatic mdl_reset();
        m_have  = 1'b0;
        idle_at = 0;
        acc_t   = 0;
        m_last  = 1'b1;
        m_gnt   = 1'b0;
        m_dat   = 9'h0;
        m_nib   = 1'b0;
    endtask

    // One clock: drive at the falling edge, compare, then let the model decide.
    task automatic step(input int rate);
        int         k;
        logic       ebusy;
        logic       ee;
        logic [3:0] ed;
        logic [1:0] er;
        logic       p;
        logic       lock_holds;
        int         len;
        @(negedge clk);
        cyc++;
        if (rel_pend) begin
            rst_n    = 1'b1;
            rel_pend = 1'b0;
        end
        for (int i = 0; i < 2; i++)
            if (!pv[i] && rate > 0 && $urandom_range(99) < rate) new_req(i);
        drive();
        #1;
        k     = cyc - acc_t;
        ebusy = m_have && (cyc < idle_at);
        ee    = ebusy && ((k > CD && k <= 2*CD) || (!m_nib && k > 3*CD && k <= 4*CD));
        ed    = !m_have ? 4'h0 : ((m_nib || k <= 2*CD) ? m_dat[7:4] : m_dat[3:0]);
        chk("busy",  32'(bus.busy),  32'(ebusy));
        chk("e",     32'(bus.e),     32'(ee));
        chk("rs",    32'(bus.rs),    32'(m_have & m_dat[8]));
        chk("d",     32'(dnib),      32'(ed));
        chk("grant", 32'(bus.grant), 32'(m_gnt));
        if (bus.req1_ready) n_r1++;
`ifdef ARB_LOCK_EN
        lock_holds = plock[m_last];
`else
        lock_holds = 1'b0;
`endif
        er = 2'b00;
        if (cyc >= idle_at && pv != 2'b00) begin
            if (pv == 2'b11) p = lock_holds ? m_last : ~m_last;
            else             p = pv[1];
            er[p]   = 1'b1;
            m_dat   = pd[p];
            m_nib   = pn[p];
            m_have  = 1'b1;
            m_last  = p;
            m_gnt   = p;
            acc_t   = cyc;
            len     = m_nib ? 2*CD + DS
                            : 4*CD + ((m_dat[8] == 1'b0 && m_dat[7:0] < 8'd4) ? DL : DS);
            idle_at = cyc + len + 1;
            pv[p]   = 1'b0;
        end
        chk("ready0", 32'(bus.req0_ready), 32'(er[0]));
        chk("ready1", 32'(bus.req1_ready), 32'(er[1]));
    endtask

    task automatic run(input int n, input int rate);
        for (int i = 0; i < n; i++) step(rate);
    endtask

    initial begin
        rst_n = 1'b0;
        pv    = 2'b00;
        pn    = 2'b00;
        pd[0] = 9'h0;
        pd[1] = 9'h0;
`ifdef ARB_LOCK_EN
        plock = 2'b00;
`endif
        drive();
        mdl_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_e",     32'(bus.e),     32'd0);
        chk("rst_rs",    32'(bus.rs),    32'd0);
        chk("rst_d",     32'(dnib),      32'd0);
        chk("rst_grant", 32'(bus.grant), 32'd0);
        q(1, 9'h141, 1'b0);
        drive();
        #1;
        chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
        rel_pend = 1'b1;

        // 'A' on port 1, clear on port 0, nibble-only write on port 0
        run(20, 0);
        q(0, {1'b0, LCD_CMD_CLEAR}, 1'b0);
        run(30, 0);
        q(0, 9'h030, 1'b1);
        run(15, 0);

        // both ports continuously valid
        run(60, 100);
        run(60, 0);

        // reset during PULSE_H, pending requests on both ports afterwards
        q(0, 9'h155, 1'b0);
        run(4, 0);
        @(negedge clk);
        cyc++;
        #1;
        chk("pulse_h_e", 32'(bus.e), 32'd1);
        q(0, 9'h1AA, 1'b0);
        q(1, 9'h142, 1'b0);
        drive();
        rst_n = 1'b0;
        #1;
        chk("abort_e",      32'(bus.e),          32'd0);
        chk("abort_busy",   32'(bus.busy),       32'd0);
        chk("abort_ready0", 32'(bus.req0_ready), 32'd0);
        chk("abort_ready1", 32'(bus.req1_ready), 32'd0);
        mdl_reset();
        repeat (2) @(negedge clk);
        rel_pend = 1'b1;
        run(60, 0);

`ifdef ARB_LOCK_EN
        plock = 2'b01;
        n_r1  = 0;
        run(70, 100);
        chk("lock_no_p1", 32'(n_r1), 32'd0);
        plock = 2'b00;
        run(60, 100);
        run(60, 0);
        rand_lock = 1'b1;
`endif

        run(1500, 30);
        run(60, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
